// File: rtl/decoder_arbiter_pkg.sv
// Shared types and defaults for the round-robin decoder arbiter.
// Optional one-hot output decode is selected with DECODER_ARB_ONEHOT_EN.
package decoder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    PRECHARGE = 2'd2
  } state_e;

  localparam int DEF_NREQ = 4;
  localparam int DEF_AW   = 5;

  // Index of the set bit in a one-hot vector (requester count is capped at 32).
  function automatic int onehot_idx(input logic [31:0] v);
    onehot_idx = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) onehot_idx = i;
  endfunction

endpackage

// File: rtl/decoder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic            valid_o
);

  int idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_i) + off) % NREQ;
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_arbiter.sv
// Arbitrates NREQ requesters onto one shared address decoder with a fixed enable pulse.
// Define DECODER_ARB_ONEHOT_EN to build the registered one-hot decode on z.
module decoder_arbiter
  import decoder_arbiter_pkg::*;
#(
  parameter int NREQ         = DEF_NREQ,
  parameter int AW           = DEF_AW,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        dec_a,
  output logic                 dec_en,
  output logic                 busy,
  output logic [(2**AW)-1:0]   z
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam int ZW = 2**AW;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [AW-1:0]   dec_a_q, dec_a_d;
  logic            dec_en_q, dec_en_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] win;
  logic            win_vld;
  int              widx;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .valid_o (win_vld)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    dec_a_d  = dec_a_q;
    dec_en_d = dec_en_q;
    widx     = onehot_idx(32'(win));
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d    = win;
          dec_a_d  = addr[widx*AW +: AW];
          dec_en_d = 1'b1;
          cnt_d    = CW'(1);
          ptr_d    = PW'((widx + 1) % NREQ);
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        // cnt_q counts enable cycles already spent, starting at 1 on the grant edge
        if (cnt_q == CW'(PULSE_CYCLES)) begin
          dec_en_d = 1'b0;
          state_d  = PRECHARGE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRECHARGE: state_d = IDLE;
      default: begin
        state_d  = IDLE;
        dec_en_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      dec_a_q  <= '0;
      dec_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      dec_a_q  <= dec_a_d;
      dec_en_q <= dec_en_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign dec_a  = dec_a_q;
  assign dec_en = dec_en_q;
  assign busy   = busy_q;

`ifdef DECODER_ARB_ONEHOT_EN
  logic [ZW-1:0] z_q, z_d;

  always_comb begin
    z_d = '0;
    if (dec_en_d) z_d = ZW'(1) << dec_a_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) z_q <= '0;
    else     z_q <= z_d;
  end

  assign z = z_q;
`else
  assign z = '0;
`endif

endmodule
